dmem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port, byte-addressed, little-endian data memory between requester 0 (CPU load/store path) and requester 1 (test loader/DMA port). Each request goes through a fixed three-state sequence: arbitrate, access, respond. The memory-side command is registered, so the memory sees a stable address, write data and one-cycle write enable. Word-aligned accesses only; a misaligned request is answered with an error and never reaches the memory.

---
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-command bundle shared by the two requesters,
// the data-memory arbiter and the data memory itself.
interface dmem_arbiter_if #(
    parameter int unsigned A_WIDTH    = 28,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  REQ0, REQ1;
    logic                  WE0, WE1;
    logic [A_WIDTH-1:0]    A0, A1;
    logic [DATA_WIDTH-1:0] WD0, WD1;
    logic                  ACK0, ACK1;
    logic [DATA_WIDTH-1:0] RD0, RD1;
    logic                  ERR0, ERR1;
    logic                  BUSY;
    logic [A_WIDTH-1:0]    MEM_A;
    logic [DATA_WIDTH-1:0] MEM_WD;
    logic                  MEM_WE;
    logic [DATA_WIDTH-1:0] MEM_RD;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, A0, A1, WD0, WD1, MEM_RD,
        output ACK0, ACK1, RD0, RD1, ERR0, ERR1, BUSY, MEM_A, MEM_WD, MEM_WE
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, A0, A1, WD0, WD1, MEM_RD,
        input  ACK0, ACK1, RD0, RD1, ERR0, ERR1, BUSY, MEM_A, MEM_WD, MEM_WE
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-aligned data memory between the CPU
// load/store path (requester 0) and the loader/DMA port (requester 1).
module dmem_arbiter #(
    parameter int unsigned A_WIDTH    = 28,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic           CLK,
    input logic           RST_N,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  sel_q, sel_d;
    logic                  mis_q, mis_d;
    logic                  we_q, we_d;
    logic [A_WIDTH-1:0]    a_q, a_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req_any;
    logic                  gnt;
    logic                  req_we;
    logic [A_WIDTH-1:0]    req_a;
    logic [DATA_WIDTH-1:0] req_wd;
    logic                  ack;

    always_comb begin
        req_any = bus.REQ0 | bus.REQ1;
        // On a tie the requester that was not served last wins.
        gnt     = (bus.REQ0 & bus.REQ1) ? ~last_q : bus.REQ1;
        req_we  = gnt ? bus.WE1 : bus.WE0;
        req_a   = gnt ? bus.A1  : bus.A0;
        req_wd  = gnt ? bus.WD1 : bus.WD0;

        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        mis_d   = mis_q;
        we_d    = we_q;
        a_d     = a_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    sel_d   = gnt;
                    last_d  = gnt;
                    a_d     = req_a;
                    wd_d    = req_wd;
                    rdata_d = '0;
                    if (req_a[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        mis_d   = 1'b0;
                        we_d    = req_we;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) rdata_d = bus.MEM_RD;
                we_d    = 1'b0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            mis_q   <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            mis_q   <= mis_d;
            we_q    <= we_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack = (state_q == RESP);

    assign bus.ACK0   = ack & ~sel_q;
    assign bus.ACK1   = ack &  sel_q;
    assign bus.ERR0   = bus.ACK0 & mis_q;
    assign bus.ERR1   = bus.ACK1 & mis_q;
    assign bus.RD0    = bus.ACK0 ? rdata_q : '0;
    assign bus.RD1    = bus.ACK1 ? rdata_q : '0;
    assign bus.BUSY   = (state_q != IDLE);
    assign bus.MEM_A  = a_q;
    assign bus.MEM_WD = wd_q;
    // Gated by reset so a reset landing in ACCESS blocks the write at that edge.
    assign bus.MEM_WE = we_q & RST_N;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: drivers push expected responses, a negedge
// monitor pops and checks them against every ACK pulse.
module tb_dmem_arbiter;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rd;
        int unsigned cyc;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    int unsigned cyc;
    int unsigned we_cnt;
    int          checks;
    int          failures;
    exp_t        expq[$];
    logic [31:0] mem [0:1023];

    dmem_arbiter_if #(.A_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(.A_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
    end
    always @(posedge CLK) if (bus.MEM_WE) mem[bus.MEM_A[11:2]] <= bus.MEM_WD;
    assign bus.MEM_RD = mem[bus.MEM_A[11:2]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic port, input logic err, input logic [31:0] rd, input int unsigned c);
        exp_t e;
        e.port = port;
        e.err  = err;
        e.rd   = rd;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (bus.MEM_WE) we_cnt++;
        if (bus.ACK0 || bus.ACK1) begin
            chk("ack_exclusive", {63'd0, bus.ACK0 & bus.ACK1}, 64'd0);
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=ack0:%0b,ack1:%0b required=none cyc=%0d",
                         bus.ACK0, bus.ACK1, cyc);
            end else begin
                e = expq.pop_front();
                chk("ack_port", {63'd0, bus.ACK1}, {63'd0, e.port});
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                if (e.port) begin
                    chk("err1", {63'd0, bus.ERR1}, {63'd0, e.err});
                    chk("rd1", {32'd0, bus.RD1}, {32'd0, e.rd});
                    chk("idle_side0", {bus.ERR0, bus.RD0}, 64'd0);
                end else begin
                    chk("err0", {63'd0, bus.ERR0}, {63'd0, e.err});
                    chk("rd0", {32'd0, bus.RD0}, {32'd0, e.rd});
                    chk("idle_side1", {bus.ERR1, bus.RD1}, 64'd0);
                end
            end
        end
    end

    initial begin
        int unsigned c;
        int unsigned w;
        checks   = 0;
        failures = 0;
        we_cnt   = 0;
        RST_N    = 1'b0;
        bus.REQ0 = 1'b0; bus.WE0 = 1'b0; bus.A0 = '0; bus.WD0 = '0;
        bus.REQ1 = 1'b0; bus.WE1 = 1'b0; bus.A1 = '0; bus.WD1 = '0;
        tick(3);

        chk("rst_busy",   {63'd0, bus.BUSY}, 64'd0);
        chk("rst_mem_we", {63'd0, bus.MEM_WE}, 64'd0);
        chk("rst_mem_a",  64'(bus.MEM_A), 64'd0);
        chk("rst_mem_wd", 64'(bus.MEM_WD), 64'd0);
        chk("rst_acks",   {60'd0, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1}, 64'd0);
        chk("rst_rd",     {bus.RD0, bus.RD1}, 64'd0);
        RST_N = 1'b1;
        tick(1);

        // Aligned write then read-back on requester 0.
        c = cyc;
        we_cnt = 0;
        bus.REQ0 = 1'b1; bus.WE0 = 1'b1; bus.A0 = 28'h0010000; bus.WD0 = 32'hDEADBEEF;
        push(1'b0, 1'b0, 32'h0, c + 2);
        tick(1);
        chk("write_mem_a",  64'(bus.MEM_A), 64'h10000);
        chk("write_mem_wd", 64'(bus.MEM_WD), 64'hDEADBEEF);
        tick(1);
        bus.REQ0 = 1'b0; bus.WE0 = 1'b0;
        tick(1);
        chk("write_we_pulses", 64'(we_cnt), 64'd1);

        c = cyc;
        bus.REQ0 = 1'b1; bus.A0 = 28'h0010000;
        push(1'b0, 1'b0, 32'hDEADBEEF, c + 2);
        tick(2);
        bus.REQ0 = 1'b0;
        tick(1);

        // Misaligned read on requester 1.
        c = cyc;
        w = we_cnt;
        bus.REQ1 = 1'b1; bus.WE1 = 1'b0; bus.A1 = 28'h0010002;
        push(1'b1, 1'b1, 32'h0, c + 1);
        tick(1);
        bus.REQ1 = 1'b0;
        tick(1);
        chk("misaligned_no_we", 64'(we_cnt), 64'(w));
        chk("misaligned_idle", {63'd0, bus.BUSY}, 64'd0);

        // Continuous contention: LAST now points at 1, so 0 wins first.
        c = cyc;
        bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.A0 = 28'h0010008;
        bus.REQ1 = 1'b1; bus.WE1 = 1'b0; bus.A1 = 28'h001000C;
        push(1'b0, 1'b0, 32'hC0DE0002, c + 2);
        push(1'b1, 1'b0, 32'hC0DE0003, c + 5);
        push(1'b0, 1'b0, 32'hC0DE0002, c + 8);
        push(1'b1, 1'b0, 32'hC0DE0003, c + 11);
        tick(11);
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        tick(1);

        // Requester 1 arrives while requester 0 is in ACCESS.
        c = cyc;
        bus.REQ0 = 1'b1; bus.WE0 = 1'b0; bus.A0 = 28'h0010010;
        push(1'b0, 1'b0, 32'hC0DE0004, c + 2);
        tick(1);
        bus.REQ1 = 1'b1; bus.WE1 = 1'b0; bus.A1 = 28'h0010014;
        push(1'b1, 1'b0, 32'hC0DE0005, c + 5);
        tick(1);
        bus.REQ0 = 1'b0;
        tick(3);
        bus.REQ1 = 1'b0;
        tick(1);

        // Reset during the ACCESS cycle of a write: no write, no ACK.
        w = we_cnt;
        bus.REQ0 = 1'b1; bus.WE0 = 1'b1; bus.A0 = 28'h0010004; bus.WD0 = 32'h12345678;
        tick(1);
        RST_N = 1'b0;
        bus.REQ0 = 1'b0; bus.WE0 = 1'b0;
        #1;
        chk("reset_access_we", {63'd0, bus.MEM_WE}, 64'd0);
        tick(1);
        RST_N = 1'b1;
        chk("reset_access_busy", {63'd0, bus.BUSY}, 64'd0);
        chk("reset_access_we_cnt", 64'(we_cnt), 64'(w));
        tick(3);

        c = cyc;
        bus.REQ0 = 1'b1; bus.A0 = 28'h0010004;
        push(1'b0, 1'b0, 32'hC0DE0001, c + 2);
        tick(2);
        bus.REQ0 = 1'b0;
        tick(1);

        // Idle bus stays quiet.
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle_quiet", {58'd0, bus.BUSY, bus.MEM_WE, bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1}, 64'd0);
        end

        chk("pending_responses", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
